alu_issue: RTL

Operand-fetch and issue stage that sits directly upstream of the 8-bit `alu`. Accepts one decoded instruction per cycle, reads operands from an internal 8x8 register file, and registers `alu_cmd`/`inA`/`inB`/`sc_i` for the combinational ALU. On the following edge it writes the ALU result and flags back. Read-after-write hazards between adjacent instructions are resolved by forwarding or, when forwarding is compiled out, by a one-cycle stall.

---
 rtl/alu_issue_pkg.sv | 23 ++
 rtl/alu_issue_if.sv | 50 +++++
 rtl/alu_issue_reg_file.sv | 37 +++
 rtl/alu_issue.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_pkg: shared widths, ALU command type and the decoded-instruction
// bundle used by the alu_issue operand-fetch/issue stage.
package alu_pkg;

  localparam int W    = 8;
  localparam int NREG = 8;
  localparam int RA_W = 3;

  typedef logic [4:0] alu_cmd_t;

  localparam alu_cmd_t CMD_LDI = 5'b00000;
  localparam alu_cmd_t CMD_ADD = 5'b00001;

  typedef struct packed {
    alu_cmd_t        cmd;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs;
    logic [W-1:0]    imm;
    logic            use_imm;
    logic            we;
  } issue_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake, ALU drive/return, writeback echo,
// architectural flags and debug read port of the issue stage.
// master = upstream/ALU side, slave = the issue stage.
interface alu_issue_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  alu_cmd_t             in_cmd;
  logic [RA_W-1:0]      in_rd;
  logic [RA_W-1:0]      in_rs;
  logic [W-1:0]         in_imm;
  logic                 in_use_imm;
  logic                 in_we;

  alu_cmd_t             alu_cmd;
  logic [W-1:0]         alu_a;
  logic [W-1:0]         alu_b;
  logic                 alu_sc_i;
  logic [W-1:0]         alu_rslt;
  logic                 alu_sc_o;
  logic                 alu_zero;
  logic                 alu_pari;

  logic                 wb_valid;
  logic [RA_W-1:0]      wb_rd;
  logic [W-1:0]         wb_data;

  logic                 flag_c;
  logic                 flag_z;
  logic                 flag_p;

  logic [RA_W-1:0]      dbg_addr;
  logic [W-1:0]         dbg_data;

  modport master (
    output in_valid, in_cmd, in_rd, in_rs, in_imm, in_use_imm, in_we,
    output alu_rslt, alu_sc_o, alu_zero, alu_pari, dbg_addr,
    input  in_ready, alu_cmd, alu_a, alu_b, alu_sc_i,
    input  wb_valid, wb_rd, wb_data, flag_c, flag_z, flag_p, dbg_data
  );

  modport slave (
    input  in_valid, in_cmd, in_rd, in_rs, in_imm, in_use_imm, in_we,
    input  alu_rslt, alu_sc_o, alu_zero, alu_pari, dbg_addr,
    output in_ready, alu_cmd, alu_a, alu_b, alu_sc_i,
    output wb_valid, wb_rd, wb_data, flag_c, flag_z, flag_p, dbg_data
  );

endinterface

// File: rtl/alu_issue_reg_file.sv
// reg_file: NREG x W register file, three combinational read ports
// (operand A, operand B, debug) and one synchronous write port.
// Synchronous reset clears every entry; reset wins over a write.
module reg_file
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] ra_addr_i,
  output logic [W-1:0]    ra_data_o,
  input  logic [RA_W-1:0] rb_addr_i,
  output logic [W-1:0]    rb_data_o,
  input  logic [RA_W-1:0] dbg_addr_i,
  output logic [W-1:0]    dbg_data_o,
  input  logic            we_i,
  input  logic [RA_W-1:0] wa_i,
  input  logic [W-1:0]    wd_i
);

  logic [W-1:0] mem_q [NREG];

  assign ra_data_o  = mem_q[ra_addr_i];
  assign rb_data_o  = mem_q[rb_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

  // Storage: clear on reset, otherwise single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: operand fetch and issue stage in front of the 8-bit ALU.
// Reads operands, registers the ALU drive (E stage), writes the ALU
// result and flags back one edge later.
// Build option ALU_ISSUE_FWD_EN: forward alu_rslt into the operands of
// a dependent next instruction; without it that instruction stalls one
// cycle so it reads the freshly written register instead.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
);

  issue_t          in_s;
  logic [W-1:0]    rf_a_s, rf_b_s;
  logic            haz_a_s, haz_b_s, accept_s;
  logic [W-1:0]    op_a_s, op_b_s;

  logic            e_valid_q, e_valid_d;
  alu_cmd_t        e_cmd_q, e_cmd_d;
  logic [RA_W-1:0] e_rd_q, e_rd_d;
  logic            e_we_q, e_we_d;
  logic [W-1:0]    e_a_q, e_a_d;
  logic [W-1:0]    e_b_q, e_b_d;

  logic            wb_valid_q, wb_valid_d;
  logic [RA_W-1:0] wb_rd_q, wb_rd_d;
  logic [W-1:0]    wb_data_q, wb_data_d;
  logic            flag_c_q, flag_c_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_p_q, flag_p_d;

  assign in_s = '{cmd: bus.in_cmd, rd: bus.in_rd, rs: bus.in_rs,
                  imm: bus.in_imm, use_imm: bus.in_use_imm, we: bus.in_we};

  reg_file u_rf (
    .clk        (clk),
    .reset      (reset),
    .ra_addr_i  (in_s.rd),
    .ra_data_o  (rf_a_s),
    .rb_addr_i  (in_s.rs),
    .rb_data_o  (rf_b_s),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data),
    .we_i       (e_valid_q && e_we_q),
    .wa_i       (e_rd_q),
    .wd_i       (bus.alu_rslt)
  );

  // Operand hazards: the instruction in E is about to write a register
  // the incoming instruction reads.
  assign haz_a_s = e_valid_q && e_we_q && (in_s.rd == e_rd_q);
  assign haz_b_s = e_valid_q && e_we_q && !in_s.use_imm && (in_s.rs == e_rd_q);

`ifdef ALU_ISSUE_FWD_EN
  assign bus.in_ready = 1'b1;
  assign op_a_s = haz_a_s ? bus.alu_rslt : rf_a_s;
  assign op_b_s = in_s.use_imm ? in_s.imm : (haz_b_s ? bus.alu_rslt : rf_b_s);
`else
  assign bus.in_ready = !(bus.in_valid && (haz_a_s || haz_b_s));
  assign op_a_s = rf_a_s;
  assign op_b_s = in_s.use_imm ? in_s.imm : rf_b_s;
`endif

  assign accept_s = bus.in_valid && bus.in_ready;

  // E-stage next state: load on accept, otherwise insert a bubble.
  always_comb begin
    e_valid_d = accept_s;
    e_cmd_d   = e_cmd_q;
    e_rd_d    = e_rd_q;
    e_we_d    = e_we_q;
    e_a_d     = e_a_q;
    e_b_d     = e_b_q;
    if (accept_s) begin
      e_cmd_d = in_s.cmd;
      e_rd_d  = in_s.rd;
      e_we_d  = in_s.we;
      e_a_d   = op_a_s;
      e_b_d   = op_b_s;
    end else begin
      e_cmd_d = e_cmd_q;
    end
  end

  // Writeback next state: capture ALU result and flags when E is valid.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    flag_c_d   = flag_c_q;
    flag_z_d   = flag_z_q;
    flag_p_d   = flag_p_q;
    if (e_valid_q) begin
      wb_valid_d = e_we_q;
      wb_rd_d    = e_rd_q;
      wb_data_d  = bus.alu_rslt;
      flag_c_d   = bus.alu_sc_o;
      flag_z_d   = bus.alu_zero;
      flag_p_d   = bus.alu_pari;
    end else begin
      wb_valid_d = 1'b0;
    end
  end

  // Pipeline and flag registers; reset drops any pending writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q  <= 1'b0;
      e_cmd_q    <= CMD_LDI;
      e_rd_q     <= {RA_W{1'b0}};
      e_we_q     <= 1'b0;
      e_a_q      <= {W{1'b0}};
      e_b_q      <= {W{1'b0}};
      wb_valid_q <= 1'b0;
      wb_rd_q    <= {RA_W{1'b0}};
      wb_data_q  <= {W{1'b0}};
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_p_q   <= 1'b0;
    end else begin
      e_valid_q  <= e_valid_d;
      e_cmd_q    <= e_cmd_d;
      e_rd_q     <= e_rd_d;
      e_we_q     <= e_we_d;
      e_a_q      <= e_a_d;
      e_b_q      <= e_b_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      flag_c_q   <= flag_c_d;
      flag_z_q   <= flag_z_d;
      flag_p_q   <= flag_p_d;
    end
  end

  assign bus.alu_cmd  = e_cmd_q;
  assign bus.alu_a    = e_a_q;
  assign bus.alu_b    = e_b_q;
  assign bus.alu_sc_i = flag_c_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.flag_c   = flag_c_q;
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_p   = flag_p_q;

endmodule
